writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameters SHALL be: ADDR, default 5, register address width; BUS_W, default 32, data width; STARVE_LIM, default 4, maximum consecutive lost cycles for a held mul/div result.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- reloj_cucu  in  1  clock; one clock only, all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_valid  in  1  MEM-stage result valid.
- pipe_ready  out  1  stage accepts MEM result.
- pipe_wen  in  1  instruction writes a register.
- pipe_rd  in  ADDR  destination register.
- pipe_is_load  in  1  select load data instead of ALU result.
- pipe_ld_type  in  3  load kind (ld_type_e).
- pipe_byte_off  in  2  load byte offset.
- pipe_alu  in  BUS_W  ALU result.
- pipe_mem_data  in  BUS_W  raw memory word.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  mul/div holding buffer empty.
- md_rd  in  ADDR  mul/div destination.
- md_result  in  BUS_W  mul/div result.
- r_write  out  1  register-file write enable.
- rd_addr  out  ADDR  register-file write address.
- rd_w_data  out  BUS_W  register-file write data.

Function
REQ-003 Pipe transfer SHALL occur when pipe_valid & pipe_ready; the result SHALL appear on r_write/rd_addr/rd_w_data exactly one cycle later (registered outputs).
REQ-004 A transfer with pipe_wen=0 or pipe_rd=0 SHALL be accepted and produce r_write=0.
REQ-005 Write data SHALL be pipe_alu when pipe_is_load=0, otherwise the aligned/extended pipe_mem_data.
REQ-006 Load alignment: LW whole word; LB/LBU byte selected by pipe_byte_off, sign/zero-extended; LH/LHU half selected by pipe_byte_off[1], sign/zero-extended; pipe_byte_off[0] ignored for halves; undefined ld_type codes SHALL behave as LW.
REQ-007 md_ready SHALL be 1 exactly when the one-entry mul/div holding buffer is empty; md_valid & md_ready SHALL capture md_rd/md_result into the buffer; a captured md_rd=0 SHALL be discarded immediately.
REQ-008 States: IDLE (buffer empty), HOLD (buffer full), FORCE (draining buffer).
REQ-009 IDLE->HOLD on capture of nonzero md_rd; captured results SHALL never be written in the capture cycle.
REQ-010 In HOLD, the buffer SHALL drain (written next cycle, -> IDLE) in any cycle without a pipe transfer that writes (pipe_valid=0, pipe_wen=0 or pipe_rd=0).
REQ-011 In HOLD, every cycle with a writing pipe transfer SHALL increment a starvation counter; on reaching STARVE_LIM, HOLD->FORCE.
REQ-012 In FORCE, pipe_ready SHALL be 0 for exactly one cycle, the buffer SHALL drain, and the state SHALL return to IDLE with the counter cleared; pipe_ready SHALL be 1 in all other states.
REQ-013 If a writing pipe transfer targets the held md rd, the buffer SHALL be discarded (younger write wins), state -> IDLE, counter cleared.
REQ-014 md capture and buffer drain in the same cycle SHALL be allowed only after the drain (md_ready follows the registered buffer state; no same-cycle refill).

Reset
REQ-015 Reset SHALL force state IDLE, counter 0, buffer empty, r_write=0, rd_addr=0, rd_w_data=0, pipe_ready=1, md_ready=1; reset mid-HOLD/FORCE SHALL drop the held result.

Configuration
REQ-016 Macro WB_SUBWORD_EN: when defined, REQ-006 applies in full; when undefined, pipe_ld_type and pipe_byte_off SHALL be ignored and every load SHALL write pipe_mem_data unmodified.

Structure
REQ-017 Package wb_pkg SHALL hold ld_type_e (LW=0, LB=1, LBU=2, LH=3, LHU=4), the wb_state_e enum, and the default STARVE_LIM.
REQ-018 Load alignment SHALL be a combinational sub-module load_align instantiated once.

Verification
REQ-019 Pipe LB, mem_data=0x1234_80FF, off=1, rd=5 -> next cycle r_write=1, rd_addr=5, rd_w_data=0xFFFF_FF80; LHU off=2 -> 0x0000_1234.
REQ-020 md result 0xDEAD_BEEF rd=9, pipe idle -> md_ready=0 one cycle, then r_write=1, rd_addr=9, data 0xDEAD_BEEF, md_ready=1.
REQ-021 md held rd=9 with continuous writing pipe traffic -> after 4 lost cycles pipe_ready=0 for one cycle and rd 9 written; no pipe result lost.
REQ-022 md held rd=7, pipe writes rd=7 value 0x11 -> only 0x11 written to 7; buffer discarded, md_ready=1.
REQ-023 Pipe write to rd=0 and md_rd=0 -> r_write stays 0; reset asserted in HOLD -> all outputs at reset values, held result never written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: load kinds, FSM states
// and the default starvation limit for a held mul/div result.
package wb_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LB  = 3'd1,
        LBU = 3'd2,
        LH  = 3'd3,
        LHU = 3'd4
    } ld_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FORCE = 2'd2
    } wb_state_e;

    localparam int STARVE_LIM_DEF = 4;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load data alignment and sign/zero extension.
// Sub-word handling exists only when WB_SUBWORD_EN is defined; otherwise the raw word passes through.
module load_align
    import wb_pkg::*;
#(
    parameter int BUS_W = 32
) (
    input  logic [BUS_W-1:0] mem_data_i,
    input  logic [2:0]       ld_type_i,
    input  logic [1:0]       byte_off_i,
    output logic [BUS_W-1:0] data_o
);

`ifdef WB_SUBWORD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_data_i[{byte_off_i, 3'b000} +: 8];
        // Halves are naturally aligned, so the low offset bit plays no part.
        half_sel = mem_data_i[{byte_off_i[1], 4'b0000} +: 16];
        case (ld_type_i)
            LB:      data_o = {{(BUS_W-8){byte_sel[7]}}, byte_sel};
            LBU:     data_o = {{(BUS_W-8){1'b0}}, byte_sel};
            LH:      data_o = {{(BUS_W-16){half_sel[15]}}, half_sel};
            LHU:     data_o = {{(BUS_W-16){1'b0}}, half_sel};
            default: data_o = mem_data_i;
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{ld_type_i, byte_off_i};
    assign data_o     = mem_data_i;
`endif

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges MEM-stage results with a one-entry mul/div holding buffer
// onto a single register-file write port. Optional sub-word loads via WB_SUBWORD_EN.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int ADDR       = 5,
    parameter int BUS_W      = 32,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic             reloj_cucu,
    input  logic             reset,
    input  logic             pipe_valid,
    output logic             pipe_ready,
    input  logic             pipe_wen,
    input  logic [ADDR-1:0]  pipe_rd,
    input  logic             pipe_is_load,
    input  logic [2:0]       pipe_ld_type,
    input  logic [1:0]       pipe_byte_off,
    input  logic [BUS_W-1:0] pipe_alu,
    input  logic [BUS_W-1:0] pipe_mem_data,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic [ADDR-1:0]  md_rd,
    input  logic [BUS_W-1:0] md_result,
    output logic             r_write,
    output logic [ADDR-1:0]  rd_addr,
    output logic [BUS_W-1:0] rd_w_data
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR-1:0]  hold_rd_q, hold_rd_d;
    logic [BUS_W-1:0] hold_data_q, hold_data_d;
    logic             r_write_q, r_write_d;
    logic [ADDR-1:0]  rd_addr_q, rd_addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;

    logic [BUS_W-1:0] load_data;
    logic [BUS_W-1:0] pipe_data;
    logic             pipe_xfer;
    logic             pipe_writes;

    load_align #(
        .BUS_W(BUS_W)
    ) u_load_align (
        .mem_data_i (pipe_mem_data),
        .ld_type_i  (pipe_ld_type),
        .byte_off_i (pipe_byte_off),
        .data_o     (load_data)
    );

    assign pipe_ready  = (state_q != FORCE);
    assign md_ready    = (state_q == IDLE);
    assign pipe_xfer   = pipe_valid & pipe_ready;
    assign pipe_writes = pipe_xfer & pipe_wen & (pipe_rd != '0);
    assign pipe_data   = pipe_is_load ? load_data : pipe_alu;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        r_write_d   = pipe_writes;
        rd_addr_d   = pipe_writes ? pipe_rd : rd_addr_q;
        wdata_d     = pipe_writes ? pipe_data : wdata_q;

        case (state_q)
            IDLE: begin
                // A captured rd=0 is simply never stored.
                if (md_valid && (md_rd != '0)) begin
                    hold_rd_d   = md_rd;
                    hold_data_d = md_result;
                    cnt_d       = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (!pipe_writes) begin
                    r_write_d = 1'b1;
                    rd_addr_d = hold_rd_q;
                    wdata_d   = hold_data_q;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (pipe_rd == hold_rd_q) begin
                    // The younger pipe write overwrites the same register: drop the held value.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(STARVE_LIM)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                r_write_d = 1'b1;
                rd_addr_d = hold_rd_q;
                wdata_d   = hold_data_q;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge reloj_cucu or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_write_q <= 1'b0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_write_q <= r_write_d;
            rd_addr_q <= rd_addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Buffer contents are only meaningful in HOLD/FORCE, so they need no reset.
    always_ff @(posedge reloj_cucu) begin
        hold_rd_q   <= hold_rd_d;
        hold_data_q <= hold_data_d;
    end

    assign r_write   = r_write_q;
    assign rd_addr   = rd_addr_q;
    assign rd_w_data = wdata_q;

endmodule
